fetch_unit: RTL and testbench

// - PC owner and instruction fetcher at the front of the RV32 pipeline.
// - Consumes the redirect/kill outputs of the jump and branch units.
// - Issues in-order word requests to instruction memory over a valid/ready handshake.
// - Buffers returned words in a small fetch queue and presents {inst, pc} to decode over valid/ready.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode handshakes of the fetch unit
interface fetch_unit_if;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;

    modport master (
        output o_imem_req_valid, o_imem_req_addr,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        output o_inst_valid, o_inst, o_inst_pc,
        input  i_inst_ready
    );

    modport slave (
        input  o_imem_req_valid, o_imem_req_addr,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        input  o_inst_valid, o_inst, o_inst_pc,
        output i_inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 PC owner, credit-limited fetcher and fetch queue
// Optional misaligned-redirect trap: FETCH_MISALIGN_CHECK_EN
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_pc_update_control,
    input  logic [31:0]  i_pc_update_val,
    input  logic         i_ignore_curr_inst,
    output logic         o_misalign_err,
    fetch_unit_if.master fu_bus
);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_STALL, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_STALL} state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_rsp_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0] r_fq_inst [FQ_DEPTH];
    logic [31:0] r_fq_pc   [FQ_DEPTH];

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_credit;
    logic        w_req_valid;
    logic        w_accept;
    logic        w_rsp;
    logic        w_halted;
    logic        w_push;
    logic        w_pop;
    logic [CW-1:0] w_out_nxt;

    assign w_redirect = i_pc_update_control;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign;
    assign w_misalign     = w_redirect & (|i_pc_update_val[1:0]);
    assign w_target       = i_pc_update_val;
    assign w_halted       = (r_state == S_HALT);
    assign o_misalign_err = r_misalign;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_misalign <= 1'b0;
        else if (w_misalign) r_misalign <= 1'b1;
    end
`else
    assign w_target       = i_pc_update_val & ~32'h3;
    assign w_halted       = 1'b0;
    assign o_misalign_err = 1'b0;
`endif

    // Credit covers words in flight plus words buffered, so a response always has a slot.
    assign w_credit    = ({1'b0, r_out_cnt} + {1'b0, r_count}) < DEPTH_W;
    assign w_req_valid = (r_state == S_FETCH) & w_credit & ~w_redirect;
    assign w_accept    = w_req_valid & fu_bus.i_imem_req_ready;
    assign w_rsp       = fu_bus.i_imem_rsp_valid;
    assign w_push      = w_rsp & (r_drop_cnt == '0) & ~w_redirect & ~w_halted;
    assign w_pop       = (r_count != '0) & (fu_bus.i_inst_ready | i_ignore_curr_inst) & ~w_redirect;
    assign w_out_nxt   = r_out_cnt + CW'(w_accept) - CW'(w_rsp);

    assign fu_bus.o_imem_req_valid = w_req_valid;
    assign fu_bus.o_imem_req_addr  = r_fetch_pc;
    assign fu_bus.o_inst_valid     = (r_count != '0) & ~w_halted;
    assign fu_bus.o_inst           = (r_count != '0) ? r_fq_inst[r_rptr] : 32'h0;
    assign fu_bus.o_inst_pc        = (r_count != '0) ? r_fq_pc[r_rptr]   : 32'h0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: if (!w_credit) w_state_nxt = S_STALL;
            S_STALL: if (w_credit)  w_state_nxt = S_FETCH;
            default: w_state_nxt = r_state;
        endcase
        if (w_redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (w_misalign)             w_state_nxt = S_HALT;
            else if (r_state != S_HALT) w_state_nxt = S_FETCH;
`else
            w_state_nxt = S_FETCH;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_cnt <= w_out_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                // Every word still in flight after this edge belongs to the old path.
                r_drop_cnt <= w_out_nxt;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_rsp && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wptr   <= r_wptr + PW'(1);
                end
                if (w_pop) r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fq_inst[r_wptr] <= fu_bus.i_imem_rsp_data;
            r_fq_pc[r_wptr]   <= r_rsp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with an in-order memory model
module tb_fetch_unit;
    localparam int FQ_DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        pc_upd;
    logic [31:0] pc_val;
    logic        ignore;
    logic        misalign;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH)) dut (
        .i_clk               (clk),
        .i_rst               (rst_n),
        .i_pc_update_control (pc_upd),
        .i_pc_update_val     (pc_val),
        .i_ignore_curr_inst  (ignore),
        .o_misalign_err      (misalign),
        .fu_bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_req_addr;
    logic [31:0] held_addr;
    logic [31:0] kill_pc;
    bit          prev_pending;
    bit          kill_armed;
    bit          mem_hold;
    bit          mem_rdy;
    bit          inst_rdy;
    int          consumed;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0000_0013 ^ {a[23:0], 8'h00};
    endfunction

    task automatic restart_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
        exp_req_addr = start;
    endtask

    task automatic cycle(input bit redir = 1'b0, input logic [31:0] rval = 32'h0);
        logic [31:0] e;
        @(negedge clk);
        pc_upd = redir;
        pc_val = rval;
        ignore = 1'b0;
        bus.i_imem_req_ready = mem_rdy;
        bus.i_imem_rsp_valid = !mem_hold && (mem_q.size() > 0);
        bus.i_imem_rsp_data  = bus.i_imem_rsp_valid ? memf(mem_q[0]) : 32'h0;
        bus.i_inst_ready     = inst_rdy;
        #1;
        if (kill_armed && !redir && bus.o_inst_valid && bus.o_inst_pc == kill_pc) begin
            ignore = 1'b1;
            bus.i_inst_ready = 1'b0;
            kill_armed = 1'b0;
        end
        #2;
        if (redir) chk("req_during_redirect", bus.o_imem_req_valid, 0);
        if (prev_pending && !redir) begin
            chk("req_hold_valid", bus.o_imem_req_valid, 1);
            chk("req_hold_addr", bus.o_imem_req_addr, held_addr);
        end
        if (bus.i_imem_rsp_valid) void'(mem_q.pop_front());
        if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
            chk("req_addr", bus.o_imem_req_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd4;
            mem_q.push_back(bus.o_imem_req_addr);
        end
        prev_pending = bus.o_imem_req_valid && !bus.i_imem_req_ready;
        held_addr    = bus.o_imem_req_addr;
        chk("credit_bound", 32'(mem_q.size() <= FQ_DEPTH), 1);
        if (!redir && bus.o_inst_valid && (ignore || bus.i_inst_ready)) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
            else begin
                e = exp_q.pop_front();
                if (ignore) chk("kill_pc", bus.o_inst_pc, kill_pc);
                else begin
                    chk("inst_pc", bus.o_inst_pc, e);
                    chk("inst_data", bus.o_inst, memf(e));
                    consumed++;
                end
            end
        end
        if (redir) begin
            restart_exp(rval & ~32'h3);
            prev_pending = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", bus.o_imem_req_valid, 0);
        chk("rst_req_addr", bus.o_imem_req_addr, 32'h0);
        chk("rst_inst_valid", bus.o_inst_valid, 0);
        chk("rst_inst", bus.o_inst, 32'h0);
        chk("rst_inst_pc", bus.o_inst_pc, 32'h0);
        chk("rst_misalign", misalign, 0);
        mem_q.delete();
        restart_exp(32'h0);
        prev_pending = 1'b0;
        kill_armed = 1'b0;
        mem_hold = 1'b0;
        pc_upd = 1'b0;
        ignore = 1'b0;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("boot_idle", bus.o_imem_req_valid, 0);
    endtask

    task automatic wait_outstanding(input int n);
        int k = 0;
        while (mem_q.size() < n && k < 20) begin
            cycle();
            k++;
        end
        chk("outstanding_reached", 32'(mem_q.size()), 32'(n));
    endtask

    initial begin
        rst_n = 1'b0;
        pc_upd = 1'b0; pc_val = 32'h0; ignore = 1'b0;
        bus.i_imem_req_ready = 1'b0;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        bus.i_inst_ready     = 1'b0;
        mem_rdy = 1'b1; inst_rdy = 1'b1; mem_hold = 1'b0;
        kill_pc = 32'h8; consumed = 0;

        // basic stream from reset
        do_reset();
        cycle();
        chk("first_req_valid", bus.o_imem_req_valid, 1);
        chk("first_req_addr", bus.o_imem_req_addr, 32'h0);
        repeat (20) cycle();
        chk("stream_progress", 32'(consumed >= 5), 1);

        // decode backpressure
        inst_rdy = 1'b0;
        repeat (8) cycle();
        chk("bp_req_dropped", bus.o_imem_req_valid, 0);
        chk("bp_head_valid", bus.o_inst_valid, 1);
        inst_rdy = 1'b1;
        consumed = 0;
        repeat (12) cycle();
        chk("bp_resume", 32'(consumed >= 3), 1);

        // kill head at pc 0x8
        do_reset();
        kill_armed = 1'b1;
        repeat (20) cycle();
        chk("kill_happened", 32'(kill_armed), 0);

        // memory not ready for 5 cycles
        mem_rdy = 1'b0;
        repeat (5) cycle();
        mem_rdy = 1'b1;
        repeat (10) cycle();

        // redirect with two requests in flight
        mem_hold = 1'b1;
        wait_outstanding(2);
        cycle(1'b1, 32'h100);
        mem_hold = 1'b0;
        cycle();
        chk("redir_flushed", bus.o_inst_valid, 0);
        consumed = 0;
        repeat (15) cycle();
        chk("redir_progress", 32'(consumed >= 3), 1);

        // misaligned redirect
        cycle(1'b1, 32'h102);
        cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign_set", misalign, 1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("halt_no_req", bus.o_imem_req_valid, 0);
            chk("halt_no_inst", bus.o_inst_valid, 0);
        end
`else
        chk("misalign_tied", misalign, 0);
        consumed = 0;
        repeat (12) cycle();
        chk("misalign_progress", 32'(consumed >= 3), 1);
`endif

        // reset in the middle of a stream
        do_reset();
        repeat (6) cycle();
        mem_hold = 1'b1;
        wait_outstanding(2);
        do_reset();
        consumed = 0;
        repeat (15) cycle();
        chk("post_reset_progress", 32'(consumed >= 3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
